// File: rtl/digipot_pkg.sv
// Shared state encoding, default parameters and tap decode helper for the
// digital potentiometer wiper controller.
package digipot_pkg;

  typedef enum logic {IDLE, BREAK} state_t;

  localparam int DEF_CHANNELS    = 2;
  localparam int DEF_TAP_BITS    = 4;
  localparam int DEF_DEFAULT_TAP = 8;
  localparam int DEF_RAMP_DIV    = 4;
  localparam int DEF_BBM_CYCLES  = 1;

  // Widest ladder the decode helper supports; channels truncate to their size.
  localparam int MAX_TAP_BITS = 8;
  localparam int MAX_TAPS     = 2**MAX_TAP_BITS;

  function automatic logic [MAX_TAPS-1:0] onehot(input logic [MAX_TAP_BITS-1:0] idx);
    logic [MAX_TAPS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/digipot_channel.sv
// One wiper: stored target, current tap position, break-before-make step FSM
// and one-hot tap switch decode.
module digipot_channel
  import digipot_pkg::*;
#(
  parameter int TAP_BITS    = DEF_TAP_BITS,
  parameter int DEFAULT_TAP = DEF_DEFAULT_TAP,
  parameter int BBM_CYCLES  = DEF_BBM_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   load_en,
  input  logic [TAP_BITS-1:0]    load_tap,
  input  logic                   zero_tgt,
  output logic [2**TAP_BITS-1:0] tap_sel,
  output logic [TAP_BITS-1:0]    pos,
  output logic                   busy
);

  localparam int TAPS  = 2**TAP_BITS;
  localparam int BBM_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
  localparam logic [TAP_BITS-1:0] TAP_MAX = '1;
  localparam logic [TAP_BITS-1:0] TAP_RST = TAP_BITS'(DEFAULT_TAP);

  function automatic logic [TAP_BITS-1:0] sat_step(input logic [TAP_BITS-1:0] cur,
                                                   input logic up, input logic dn);
    logic [TAP_BITS-1:0] r;
    r = cur;
    if (up && !dn && cur != TAP_MAX)
      r = cur + TAP_BITS'(1);
    else if (dn && !up && cur != '0)
      r = cur - TAP_BITS'(1);
    return r;
  endfunction

  function automatic logic [TAPS-1:0] decode(input logic [TAP_BITS-1:0] idx);
    return TAPS'(onehot(MAX_TAP_BITS'(idx)));
  endfunction

  state_t              state;
  logic                dir;
  logic [BBM_W-1:0]    bbm_cnt;
  logic [TAP_BITS-1:0] target;
  logic [TAP_BITS-1:0] eff_tgt;
  logic [TAP_BITS-1:0] step_pos;

  assign eff_tgt  = zero_tgt ? '0 : target;
  assign step_pos = dir ? pos + TAP_BITS'(1) : pos - TAP_BITS'(1);
  assign busy     = (pos != eff_tgt) || (state == BREAK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target  <= TAP_RST;
      pos     <= TAP_RST;
      tap_sel <= decode(TAP_RST);
      state   <= IDLE;
      dir     <= 1'b0;
      bbm_cnt <= '0;
    end else begin
      target <= load_en ? load_tap : sat_step(target, inc, dec);
      case (state)
        IDLE: begin
          if (tick && pos != eff_tgt) begin
            dir     <= (eff_tgt > pos);
            tap_sel <= '0;
            bbm_cnt <= '0;
            state   <= BREAK;
          end
        end
        BREAK: begin
          // The step is committed once started; target changes wait for the next tick.
          if (bbm_cnt == BBM_W'(BBM_CYCLES - 1)) begin
            pos     <= step_pos;
            tap_sel <= decode(step_pos);
            state   <= IDLE;
          end else begin
            bbm_cnt <= bbm_cnt + BBM_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/digipot_wiper_ctrl.sv
// Multi-channel digipot wiper controller: shared ramp prescaler, one-deep load
// slot and optional mute (DIGIPOT_MUTE_EN) around per-channel wipers.
module digipot_wiper_ctrl
  import digipot_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int TAP_BITS    = DEF_TAP_BITS,
  parameter int DEFAULT_TAP = DEF_DEFAULT_TAP,
  parameter int RAMP_DIV    = DEF_RAMP_DIV,
  parameter int BBM_CYCLES  = DEF_BBM_CYCLES,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAPS       = 2**TAP_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          inc,
  input  logic [CHANNELS-1:0]          dec,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [CH_W-1:0]              load_ch,
  input  logic [TAP_BITS-1:0]          load_tap,
  output logic [CHANNELS*TAPS-1:0]     tap_sel,
  output logic [CHANNELS*TAP_BITS-1:0] wiper_pos,
  output logic [CHANNELS-1:0]          busy
`ifdef DIGIPOT_MUTE_EN
  ,
  input  logic                         mute
`endif
);

  localparam int PS_W = $clog2(RAMP_DIV);

  logic [PS_W-1:0]     ps_cnt;
  logic                tick;
  logic                pend_vld;
  logic [CH_W-1:0]     pend_ch;
  logic [TAP_BITS-1:0] pend_tap;
  logic                zero_tgt;
  logic                accept;

`ifdef DIGIPOT_MUTE_EN
  assign zero_tgt = mute;
`else
  assign zero_tgt = 1'b0;
`endif

  assign tick       = (ps_cnt == PS_W'(RAMP_DIV - 1));
  assign load_ready = !pend_vld;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt   <= '0;
      pend_vld <= 1'b0;
    end else begin
      ps_cnt   <= tick ? '0 : ps_cnt + PS_W'(1);
      pend_vld <= accept;
    end
  end

  // Slot payload only matters while pend_vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_ch  <= load_ch;
      pend_tap <= load_tap;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    digipot_channel #(
      .TAP_BITS    (TAP_BITS),
      .DEFAULT_TAP (DEFAULT_TAP),
      .BBM_CYCLES  (BBM_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .inc      (inc[c]),
      .dec      (dec[c]),
      .load_en  (pend_vld && (pend_ch == CH_W'(c))),
      .load_tap (pend_tap),
      .zero_tgt (zero_tgt),
      .tap_sel  (tap_sel[c*TAPS +: TAPS]),
      .pos      (wiper_pos[c*TAP_BITS +: TAP_BITS]),
      .busy     (busy[c])
    );
  end

endmodule

// File: tb/tb_digipot_wiper_ctrl.sv
// Directed bench for digipot_wiper_ctrl at default parameters; the mute
// scenario is built only when DIGIPOT_MUTE_EN is defined.
module tb_digipot_wiper_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  inc;
  logic [1:0]  dec;
  logic        load_valid;
  logic        load_ready;
  logic [0:0]  load_ch;
  logic [3:0]  load_tap;
  logic [31:0] tap_sel;
  logic [7:0]  wiper_pos;
  logic [1:0]  busy;
`ifdef DIGIPOT_MUTE_EN
  logic        mute;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digipot_wiper_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .dec        (dec),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_tap   (load_tap),
    .tap_sel    (tap_sel),
    .wiper_pos  (wiper_pos),
    .busy       (busy)
`ifdef DIGIPOT_MUTE_EN
    ,
    .mute       (mute)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one load request; returns at the negedge inside cycle N+1.
  task automatic do_load(input logic [0:0] ch, input logic [3:0] tap);
    load_valid = 1'b1;
    load_ch    = ch;
    load_tap   = tap;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Follows one channel until it settles at goal, checking every step is a
  // single tap in the given direction, preceded by exactly one open cycle,
  // four cycles after the previous one, and that tap_sel is never multi-hot.
  task automatic ramp_watch(input int ch, input logic [3:0] goal, input bit up,
                            input int max_cyc, output int steps);
    logic [15:0] cur;
    logic [3:0]  p, prev;
    int          zrun, last, bad;
    bit          done;
    prev = wiper_pos[ch*4 +: 4];
    zrun = 0; last = -1; bad = 0; steps = 0; done = 1'b0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      cur = tap_sel[ch*16 +: 16];
      p   = wiper_pos[ch*4 +: 4];
      if (cur == 16'h0) begin
        zrun++;
        if (p != prev) bad++;
      end else begin
        if (cur != (16'h0001 << p)) bad++;
        if (p != prev) begin
          steps++;
          check("step_dir", 64'(p), up ? 64'(prev + 4'd1) : 64'(prev - 4'd1));
          check("bbm_gap", 64'(zrun), 64'd1);
          if (last >= 0) check("step_spacing", 64'(cyc - last), 64'd4);
          last = cyc;
          prev = p;
        end else if (zrun != 0) begin
          bad++;
        end
        zrun = 0;
        if (p == goal && !busy[ch]) done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    check("ramp_settled", 64'(done), 64'd1);
    check("tap_sel_shape", 64'(bad), 64'd0);
  endtask

  initial begin
    int  steps;
    bit  found;
    rst = 1'b1; inc = '0; dec = '0;
    load_valid = 1'b0; load_ch = '0; load_tap = '0;
`ifdef DIGIPOT_MUTE_EN
    mute = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_tap_sel", 64'(tap_sel), 64'h0100_0100);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tap_sel_after", 64'(tap_sel), 64'h0100_0100);
    check("rst_wiper_pos", 64'(wiper_pos), 64'h88);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_load_ready", 64'(load_ready), 64'h1);

    // Load ch0 = 11: ready low for one cycle, then three spaced steps.
    do_load(1'b0, 4'd11);
    check("load_ready_low", 64'(load_ready), 64'h0);
    @(negedge clk);
    check("load_ready_back", 64'(load_ready), 64'h1);
    check("busy_after_load", 64'(busy[0]), 64'h1);
    ramp_watch(0, 4'd11, 1'b1, 60, steps);
    check("ch0_steps", 64'(steps), 64'd3);
    check("ch0_pos_11", 64'(wiper_pos[3:0]), 64'd11);
    check("ch0_sel_11", 64'(tap_sel[15:0]), 64'h0800);
    check("ch1_untouched", 64'(wiper_pos[7:4]), 64'd8);

    // Ten dec pulses on ch1 saturate at 0; one more dec does nothing.
    for (int i = 0; i < 10; i++) begin
      dec = 2'b10;
      @(negedge clk);
    end
    dec = 2'b00;
    ramp_watch(1, 4'd0, 1'b0, 60, steps);
    check("ch1_pos_0", 64'(wiper_pos[7:4]), 64'd0);
    check("ch1_sel_0", 64'(tap_sel[31:16]), 64'h0001);
    dec = 2'b10;
    @(negedge clk);
    dec = 2'b00;
    check("dec_sat_busy", 64'(busy[1]), 64'h0);
    repeat (8) @(negedge clk);
    check("dec_sat_pos", 64'(wiper_pos[7:4]), 64'd0);

    // Pending load beats inc on ch0; inc+dec together leave ch1 alone.
    do_load(1'b0, 4'd3);
    inc = 2'b11;
    dec = 2'b10;
    @(negedge clk);
    inc = 2'b00;
    dec = 2'b00;
    check("incdec_ch1_busy", 64'(busy[1]), 64'h0);
    check("load_ch0_busy", 64'(busy[0]), 64'h1);
    ramp_watch(0, 4'd3, 1'b0, 60, steps);
    check("ch0_pos_3", 64'(wiper_pos[3:0]), 64'd3);
    check("ch1_still_0", 64'(wiper_pos[7:4]), 64'd0);

    // inc saturates at the top tap.
    do_load(1'b1, 4'd15);
    ramp_watch(1, 4'd15, 1'b1, 80, steps);
    check("ch1_pos_15", 64'(wiper_pos[7:4]), 64'd15);
    inc = 2'b10;
    @(negedge clk);
    inc = 2'b00;
    check("inc_sat_busy", 64'(busy[1]), 64'h0);
    check("inc_sat_sel", 64'(tap_sel[31:16]), 64'h8000);

    // Reset asserted inside the open-tap gap of an 8->9 step.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_load(1'b0, 4'd9);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (tap_sel[15:0] == 16'h0) found = 1'b1;
      else @(negedge clk);
    end
    check("break_seen", 64'(found), 64'd1);
    check("break_pos_held", 64'(wiper_pos[3:0]), 64'd8);
    rst = 1'b1;
    #1;
    check("midstep_rst_sel", 64'(tap_sel[15:0]), 64'h0100);
    check("midstep_rst_pos", 64'(wiper_pos[3:0]), 64'd8);
    check("midstep_rst_busy", 64'(busy), 64'h0);
    check("midstep_rst_ready", 64'(load_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef DIGIPOT_MUTE_EN
    do_load(1'b0, 4'd12);
    ramp_watch(0, 4'd12, 1'b1, 60, steps);
    check("mute_pre_pos", 64'(wiper_pos[3:0]), 64'd12);
    mute = 1'b1;
    @(negedge clk);
    ramp_watch(0, 4'd0, 1'b0, 80, steps);
    check("mute_pos_0", 64'(wiper_pos[3:0]), 64'd0);
    inc = 2'b01;
    @(negedge clk);
    inc = 2'b00;
    check("mute_inc_busy", 64'(busy[0]), 64'h0);
    repeat (6) @(negedge clk);
    check("mute_inc_pos", 64'(wiper_pos[3:0]), 64'd0);
    mute = 1'b0;
    @(negedge clk);
    ramp_watch(0, 4'd13, 1'b1, 80, steps);
    check("unmute_pos_13", 64'(wiper_pos[3:0]), 64'd13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/digipot_wiper_ctrl.md
Name: digipot_wiper_ctrl

Overview:
Parametrised multi-channel wiper controller for the on-chip digital potentiometer. Drives the analog resistor-ladder tap switches, one one-hot select bus per channel. Wiper targets come from inc/dec pulses or a load handshake. The wiper slews one tap per ramp tick, with a break-before-make gap so that no two taps are ever shorted. Sits between the pin/debounce logic of the top-level and the analog ladder on ua[].

Parameters:
CHANNELS, 2, number of independent wipers
TAP_BITS, 4, tap index width; taps per channel = 2**TAP_BITS
DEFAULT_TAP, 8, wiper and target value after reset (must be < 2**TAP_BITS)
RAMP_DIV, 4, clock cycles per ramp tick (>=2)
BBM_CYCLES, 1, cycles for which all taps are open between steps (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
inc  in  CHANNELS  per-channel single-cycle pulse; target+1, saturating
dec  in  CHANNELS  per-channel single-cycle pulse; target-1, saturating
load_valid  in  1  load request
load_ready  out  1  load slot free
load_ch  in  $clog2(CHANNELS) (min 1)  channel to load
load_tap  in  TAP_BITS  new target
tap_sel  out  CHANNELS*2**TAP_BITS  one-hot tap switches; channel c at [c*2**TAP_BITS +: 2**TAP_BITS]
wiper_pos  out  CHANNELS*TAP_BITS  current wiper index per channel
busy  out  CHANNELS  channel position != target, or step in progress
mute  in  1  present only with DIGIPOT_MUTE_EN

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values:
  - pos = target = DEFAULT_TAP for all channels.
  - tap_sel is one-hot at DEFAULT_TAP.
  - wiper_pos = DEFAULT_TAP; busy = 0; load_ready = 1; prescaler = 0; all channels IDLE.
- Load handshake:
  - Accept when load_valid & load_ready at edge N; the fields are captured into a one-deep pending slot.
  - load_ready = 0 during cycle N+1. The target is written at edge N+1, then load_ready returns to 1.
  - load_ch >= CHANNELS: the load is accepted and discarded.
- Target update priority per channel in a cycle:
  - A pending load applies and overrides inc/dec.
  - inc & dec together: no change.
  - inc at 2**TAP_BITS-1, or dec at 0: no change (saturate, no wrap).
- Prescaler: free-running 0..RAMP_DIV-1, shared by all channels. tick = (count == RAMP_DIV-1).
- Per-channel FSM:
  - IDLE: on tick with pos != target, latch dir = (target > pos) and go to BREAK.
  - BREAK: the channel's tap_sel is all zero for exactly BBM_CYCLES cycles. Then pos <= pos ± 1 per the latched dir, tap_sel becomes one-hot at the new pos in the same edge, and the FSM returns to IDLE.
  - A target change during BREAK does not abort the step. It is re-evaluated at the next tick.
- Latency: each step takes at most RAMP_DIV cycles of tick wait plus BBM_CYCLES. Slew is 1 tap per tick maximum. If BBM_CYCLES >= RAMP_DIV, ticks seen during BREAK are ignored.
- Output rules:
  - tap_sel is never multi-hot.
  - Outside BREAK it is exactly one-hot at pos.
  - wiper_pos changes only at the end of BREAK.
- busy = (pos != target) | (state == BREAK).
- rst asserted mid-step: immediately returns to the reset values above, asynchronously.

Optional Feature:
DIGIPOT_MUTE_EN.
- Defined: the mute port exists. While mute = 1, the effective target is 0 for all channels and wipers ramp down normally. Stored targets still accept load/inc/dec. On release, wipers ramp back to the stored targets. busy uses the effective target.
- Undefined: no mute port; the effective target is always the stored target.

Decomposition:
- Package digipot_pkg:
  - state enum {IDLE, BREAK}
  - default parameter constants
  - function onehot(idx)
- One sub-module, digipot_channel: per-channel target, pos and FSM, plus one-hot decode. Instantiated CHANNELS times via generate.
- The parent holds the prescaler, load slot and mute.

Test Plan:
- Reset with defaults -> tap_sel[15:0] = 16'h0100, wiper_pos = 8, busy = 0, load_ready = 1.
- Load ch0 = 11 -> load_ready low 1 cycle; ch0 steps 8→9→10→11. Each step is preceded by exactly 1 all-zero tap_sel cycle, and steps are 4 cycles apart. busy drops after pos = 11.
- Pulse dec ch1 ten times at pos 8 -> target saturates at 0; wiper ramps to 0 and stays. One further dec -> no change.
- Same cycle: load ch0 = 3 with inc[0] = 1, and inc[1] & dec[1] -> ch0 target = 3, ch1 target unchanged.
- Assert rst during the BREAK of an 8→9 step -> tap_sel immediately returns to one-hot 8, FSM IDLE, busy = 0.
- DIGIPOT_MUTE_EN: ch0 at 12, mute = 1 -> ramps to 0. inc during mute moves the stored target to 13. Release mute -> ramps 0→13.
